gr_wb_arbiter: RTL
==================

Name: gr_wb_arbiter

Overview:
- Shares the single general-register-file write port between NREQ writeback requesters (ALU execute result, load-data return, host/debug poke).
- Grants one requester per cycle round-robin and drives a registered write command (wb_en/wb_rd/wb_data) into the register file.
- Keeps a pending-write scoreboard so issue logic can detect RAW hazards on in-flight destinations.

Parameters:
- NREQ, 3, number of writeback requesters (index 0 = execute, 1 = load, 2 = host)
- XLEN, 32, register data width
- NREG, 16, number of implemented general registers; rd values >= NREG are illegal

Ports:
- clk  input  1  clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- req_valid  input  NREQ  requester i has a write pending
- req_rd  input  NREQ x 5  destination register per requester
- req_data  input  NREQ x XLEN  write data per requester
- req_ready  output  NREQ  combinational grant; handshake completes when valid & ready
- wb_en  output  1  register-file write enable (registered)
- wb_rd  output  5  register-file write index (registered)
- wb_data  output  XLEN  register-file write data (registered)
- err_illegal_rd  output  1  one-cycle pulse: an accepted request had rd >= NREG
- pend_set_valid  input  1  issue stage marks pend_set_rd as having an in-flight producer
- pend_set_rd  input  5  register to mark pending
- pend_mask  output  NREG  bit r = 1 while a write to register r is outstanding

Behaviour:
- Reset (reset = 0, async): wb_en = 0, wb_rd = 0, wb_data = 0, err_illegal_rd = 0, pend_mask = 0, round-robin pointer = 0. req_ready = 0 while reset is asserted. An accepted but not yet written request is discarded.
- Arbitration:
  - Search starts at pointer p and goes p, p+1, ... mod NREQ.
  - The first i with req_valid[i] = 1 gets req_ready[i] = 1; every other ready bit is 0.
  - At most one grant per cycle.
  - After a grant to i, p <= (i+1) mod NREQ at the edge. With no valid requesters, p is unchanged.
- The register file never stalls, so a grant always completes the handshake that cycle.
- Requester obligation: hold rd and data stable while valid = 1 and ready = 0. Dropping valid before the grant is allowed; the request is withdrawn.
- Fairness bound: a continuously valid requester is granted within NREQ cycles.
- Latency: a request accepted in cycle t produces wb_en / wb_rd / wb_data valid in cycle t+1, for exactly one cycle unless a new grant follows. Back-to-back grants give back-to-back writes.
- If no grant occurs in cycle t: wb_en = 0 in t+1; wb_rd and wb_data hold their previous values.
- rd = 0: the request is accepted and p advances, but wb_en stays 0 (x0 reads as zero) and err_illegal_rd stays 0.
- rd >= NREG: the request is accepted, wb_en stays 0, and err_illegal_rd = 1 in t+1. pend_mask is untouched.
- Scoreboard:
  - pend_set_valid with 1 <= pend_set_rd < NREG sets pend_mask[pend_set_rd] at the edge. rd 0 and illegal rd are ignored.
  - An accepted legal write to r != 0 clears pend_mask[r] at the acceptance edge, so pend_mask[r] is already 0 in cycle t+1 while wb_en is high.
  - Set and clear of the same r at the same edge: set wins and the bit stays 1 (a new producer has issued).
  - Set and clear of different registers at the same edge: both take effect.
- pend_mask[0] is always 0.

Test Plan:
- Reset release, no requests -> all outputs 0 and pend_mask = 0; after 3 idle cycles, outputs unchanged.
- req_valid = 3'b111 held for 6 cycles with rd = 1/2/3 -> grants in order 0,1,2,0,1,2; wb_rd sequence 1,2,3,1,2,3 starting one cycle after the first grant; wb_en high on 6 consecutive cycles.
- pend_set_valid with rd = 5 at cycle 0, then req1 write rd = 5, data 32'hDEAD_BEEF, accepted at cycle 2 -> pend_mask[5] = 1 in cycles 1-2 and 0 from cycle 3; wb_en = 1, wb_rd = 5, wb_data = 32'hDEAD_BEEF in cycle 3.
- Same-edge conflict: req0 write rd = 7 accepted in the same cycle as pend_set_valid rd = 7 -> pend_mask[7] = 1 afterwards; wb_en = 1, wb_rd = 7 in the next cycle.
- req2 with rd = 0, then req2 with rd = 20 -> both get req_ready; wb_en stays 0 for both; err_illegal_rd pulses exactly once, one cycle after the rd = 20 grant.
- reset driven low asynchronously mid-cycle, right after req0 is granted -> wb_en goes 0 immediately with no clock edge; no write appears after reset is released; pointer restarts at 0 (req0 wins against req1/req2 all valid).

Source files
------------

// File: rtl/gr_wb_arbiter.sv
// Round-robin arbiter sharing the general-register-file write port between
// NREQ writeback requesters, with a pending-write scoreboard for RAW detection.
module gr_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int NREG = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0][4:0]       req_rd,
  input  logic [NREQ-1:0][XLEN-1:0]  req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic                       wb_en,
  output logic [4:0]                 wb_rd,
  output logic [XLEN-1:0]            wb_data,
  output logic                       err_illegal_rd,
  input  logic                       pend_set_valid,
  input  logic [4:0]                 pend_set_rd,
  output logic [NREG-1:0]            pend_mask
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            wb_en_q, wb_en_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            err_q, err_d;
  logic [NREG-1:0] pend_q, pend_d;

  logic            gnt_any;
  logic [PW-1:0]   gnt_idx;
  logic [4:0]      gnt_rd;
  logic            rd_legal;

  // Two passes: indices at/after the pointer first, then the wrapped-around ones.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_any && req_valid[i] && (i >= int'(ptr_q))) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_any && req_valid[i] && (i < int'(ptr_q))) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(i);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_any && reset) req_ready[gnt_idx] = 1'b1;
  end

  assign gnt_rd   = req_rd[gnt_idx];
  assign rd_legal = int'(gnt_rd) < NREG;

  always_comb begin
    wb_en_d   = gnt_any && rd_legal && (gnt_rd != 5'd0);
    err_d     = gnt_any && !rd_legal;
    wb_rd_d   = gnt_any ? gnt_rd : wb_rd_q;
    wb_data_d = gnt_any ? req_data[gnt_idx] : wb_data_q;

    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);

    // Clear first so a same-edge set from a newly issued producer wins.
    pend_d = pend_q;
    for (int r = 1; r < NREG; r++) begin
      if (wb_en_d && (int'(gnt_rd) == r)) pend_d[r] = 1'b0;
      if (pend_set_valid && (int'(pend_set_rd) == r)) pend_d[r] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q     <= '0;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
      pend_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
      pend_q    <= pend_d;
    end
  end

  assign wb_en          = wb_en_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign err_illegal_rd = err_q;
  assign pend_mask      = pend_q;

endmodule
